sprite_blit_engine: RTL and testbench

- Parametrised sprite/bitmap blitter that copies a header-prefixed bitmap from one of N_SRC synchronous ROMs into the linear video memory at pixel (xloc,yloc).
- Supports add and remove modes, a transparency key, screen-edge handling, and a start/busy/done handshake.
- Sits between the game-control CPU registers and the videoMem write port.
- Generalises the 6-bit bitmap placer to any pixel width, screen size and source count, and makes completion observable.

---
 rtl/sprite_blit_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_engine.sv
// Sprite blitter: copies a header-prefixed bitmap from one of N_SRC ROMs into linear video memory.
// Optional per-pixel screen-edge clipping is enabled by defining SPRITE_CLIP_EN.
module sprite_blit_engine #(
    parameter int PIX_W   = 6,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int VADDR_W = 19,
    parameter int ROM_AW  = 16,
    parameter int N_SRC   = 4,
    parameter int SEL_W   = 2,
    parameter logic [PIX_W-1:0] TRANSP   = 6'h24,
    parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     remove,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [9:0]               xloc,
    input  logic [8:0]               yloc,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [N_SRC*PIX_W-1:0]   rom_data,
    output logic                     vm_we,
    output logic [VADDR_W-1:0]       vm_waddr,
    output logic [PIX_W-1:0]         vm_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int DW   = 2 * PIX_W;
    localparam int XS_W = ((DW > 10) ? DW : 10) + 1;
    localparam logic [VADDR_W-1:0] SCR_W_V = VADDR_W'(SCR_W);

    typedef enum logic [1:0] {IDLE, HDR, PIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           hdr_cnt_q, hdr_cnt_d;
    logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
    logic                 remove_q, remove_d;
    logic [SEL_W-1:0]     src_sel_q, src_sel_d;
    logic [9:0]           xloc_q, xloc_d;
    logic [8:0]           yloc_q, yloc_d;
    logic [DW-1:0]        width_q, width_d;
    logic [DW-1:0]        height_q, height_d;
    logic [DW-1:0]        col_q, col_d;
    logic [DW-1:0]        row_q, row_d;
    logic [VADDR_W-1:0]   row_base_q, row_base_d;
    logic [VADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic                 first_q, first_d;
    logic                 drain_q, drain_d;
    logic                 dvalid_q, dvalid_d;
    logic                 dclip_q, dclip_d;
    logic [VADDR_W-1:0]   daddr_q, daddr_d;

    logic [PIX_W-1:0]     src_pix;
    logic [DW-1:0]        h_eff;
    logic                 clip_hit;
    logic                 last_col;
    logic                 last_pix;

    // The ROM slice follows the src_sel latched at acceptance; out-of-range indices fall back to ROM 0.
    always_comb begin
        src_pix = rom_data[PIX_W-1:0];
        for (int k = 1; k < N_SRC; k++) begin
            if (32'(src_sel_q) == k) begin
                src_pix = rom_data[k*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
`ifdef SPRITE_CLIP_EN
        clip_hit = ((XS_W'(xloc_q) + XS_W'(col_q)) >= XS_W'(SCR_W)) ||
                   ((XS_W'(yloc_q) + XS_W'(row_q)) >= XS_W'(SCR_H));
`else
        clip_hit = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        rom_addr_d = rom_addr_q;
        remove_d   = remove_q;
        src_sel_d  = src_sel_q;
        xloc_d     = xloc_q;
        yloc_d     = yloc_q;
        width_d    = width_q;
        height_d   = height_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        pix_addr_d = pix_addr_q;
        first_d    = first_q;
        drain_d    = drain_q;
        dvalid_d   = 1'b0;
        dclip_d    = 1'b0;
        daddr_d    = daddr_q;
        h_eff      = height_q;
        last_col   = 1'b0;
        last_pix   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HDR;
                    remove_d   = remove;
                    src_sel_d  = src_sel;
                    xloc_d     = xloc;
                    yloc_d     = yloc;
                    hdr_cnt_d  = 2'd0;
                    rom_addr_d = '0;
                    first_d    = 1'b0;
                    drain_d    = 1'b0;
                end
            end

            // Header data trails its address by one cycle, so word k is captured while address k+1 is out.
            HDR: begin
                rom_addr_d = rom_addr_q + ROM_AW'(1);
                hdr_cnt_d  = hdr_cnt_q + 2'd1;
                case (hdr_cnt_q)
                    2'd0: begin
                        row_base_d = VADDR_W'(yloc_q) * SCR_W_V + VADDR_W'(xloc_q);
                        pix_addr_d = VADDR_W'(yloc_q) * SCR_W_V + VADDR_W'(xloc_q);
                        col_d      = '0;
                        row_d      = '0;
                    end
                    2'd1: width_d  = {src_pix, width_q[PIX_W-1:0]};
                    2'd2: width_d  = {width_q[DW-1:PIX_W], src_pix};
                    default: begin
                        height_d = {src_pix, height_q[PIX_W-1:0]};
                        state_d  = PIX;
                        first_d  = 1'b1;
                    end
                endcase
            end

            PIX: begin
                first_d = 1'b0;
                if (first_q) begin
                    h_eff    = {height_q[DW-1:PIX_W], src_pix};
                    height_d = h_eff;
                end
                last_col = (col_q == width_q - DW'(1));
                last_pix = last_col && (row_q == h_eff - DW'(1));

                if (drain_q) begin
                    state_d = DONE;
                end else if (first_q && ((width_q == '0) || (h_eff == '0))) begin
                    state_d = DONE;
                end else begin
                    dvalid_d   = 1'b1;
                    dclip_d    = clip_hit;
                    daddr_d    = pix_addr_q;
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                    // Row stepping is add-only: the multiplier above runs once per blit.
                    if (last_col) begin
                        col_d      = '0;
                        row_d      = row_q + DW'(1);
                        row_base_d = row_base_q + SCR_W_V;
                        pix_addr_d = row_base_q + SCR_W_V;
                    end else begin
                        col_d      = col_q + DW'(1);
                        pix_addr_d = pix_addr_q + VADDR_W'(1);
                    end
                    if (last_pix) begin
                        drain_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                drain_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= 2'd0;
            rom_addr_q <= '0;
            remove_q   <= 1'b0;
            src_sel_q  <= '0;
            xloc_q     <= '0;
            yloc_q     <= '0;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            pix_addr_q <= '0;
            first_q    <= 1'b0;
            drain_q    <= 1'b0;
            dvalid_q   <= 1'b0;
            dclip_q    <= 1'b0;
            daddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            rom_addr_q <= rom_addr_d;
            remove_q   <= remove_d;
            src_sel_q  <= src_sel_d;
            xloc_q     <= xloc_d;
            yloc_q     <= yloc_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            pix_addr_q <= pix_addr_d;
            first_q    <= first_d;
            drain_q    <= drain_d;
            dvalid_q   <= dvalid_d;
            dclip_q    <= dclip_d;
            daddr_q    <= daddr_d;
        end
    end

    // Write strobe and data are formed in the cycle the ROM returns the pixel; address and flags were registered at issue.
    assign vm_we    = dvalid_q && !dclip_q && (src_pix != TRANSP);
    assign vm_wdata = dvalid_q ? (remove_q ? BG_COLOR : src_pix) : '0;
    assign vm_waddr = daddr_q;
    assign rom_addr = rom_addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Scoreboard bench for sprite_blit_engine: expected writes are queued per blit and popped as vm_we fires.
module tb_sprite_blit_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        remove;
    logic [1:0]  src_sel;
    logic [9:0]  xloc;
    logic [8:0]  yloc;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        vm_we;
    logic [18:0] vm_waddr;
    logic [5:0]  vm_wdata;
    logic        busy;
    logic        done;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] rom_mem [4][256];
    logic [5:0] spr_pix [256];
    int         tests_run = 0;
    int         tests_failed = 0;

    sprite_blit_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .remove   (remove),
        .src_sel  (src_sel),
        .xloc     (xloc),
        .yloc     (yloc),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .vm_we    (vm_we),
        .vm_waddr (vm_waddr),
        .vm_wdata (vm_wdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Four synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            rom_data[k*6 +: 6] <= rom_mem[k][rom_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Other ROMs get a 1x1 decoy so a live-src_sel mux would show up as wrong data and timing.
    task automatic loadSprite(input int sel, input int w, input int h);
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 256; a++) rom_mem[k][a] = 6'h3F;
            if (k == sel) begin
                rom_mem[k][0] = 6'((w >> 6) & 63);
                rom_mem[k][1] = 6'(w & 63);
                rom_mem[k][2] = 6'((h >> 6) & 63);
                rom_mem[k][3] = 6'(h & 63);
                for (int i = 0; i < w * h; i++) rom_mem[k][4 + i] = spr_pix[i];
            end else begin
                rom_mem[k][0] = 6'd0;
                rom_mem[k][1] = 6'd1;
                rom_mem[k][2] = 6'd0;
                rom_mem[k][3] = 6'd1;
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 0);
        checkOutput({tag, "_vm_we"}, 32'(vm_we), 0);
        checkOutput({tag, "_vm_waddr"}, 32'(vm_waddr), 0);
        checkOutput({tag, "_vm_wdata"}, 32'(vm_wdata), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic applyStimulus(input int sel, input bit rem, input int x, input int y,
                                 input int w, input int h, input int repulse_cyc, input int reset_cyc);
        int  c;
        int  done_exp;
        bit  seen_done;
        bit  aborted;
        bit  keep;
        int  p;
        exp_t e;

        loadSprite(sel, w, h);
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                p = int'(spr_pix[r * w + cc]);
                keep = (p != 'h24);
`ifdef SPRITE_CLIP_EN
                if ((x + cc >= 640) || (y + r >= 480)) keep = 1'b0;
`endif
                if (keep) begin
                    e.addr = (y * 640 + x + r * 640 + cc) & 'h7FFFF;
                    e.data = rem ? 0 : p;
                    e.cyc  = 6 + r * w + cc;
                    exp_q.push_back(e);
                end
            end
        end
        done_exp = 6 + w * h;

        @(negedge clk);
        start   = 1'b1;
        remove  = rem;
        src_sel = 2'(sel);
        xloc    = 10'(x);
        yloc    = 9'(y);
        @(negedge clk);
        start   = 1'b0;
        src_sel = 2'(sel ^ 1);
        xloc    = 10'd0;
        yloc    = 9'd0;
        remove  = ~rem;

        c = 1;
        seen_done = 1'b0;
        aborted = 1'b0;
        while (!seen_done && !aborted && c <= done_exp + 8) begin
            start = (c == repulse_cyc);
            if (vm_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_write", 32'(vm_we), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("waddr", 32'(vm_waddr), e.addr);
                    checkOutput("wdata", 32'(vm_wdata), e.data);
                    checkOutput("wcycle", c, e.cyc);
                end
            end
            checkOutput("busy", 32'(busy), 1);
            if (done) begin
                checkOutput("done_cycle", c, done_exp);
                seen_done = 1'b1;
            end
            if (c == reset_cyc) begin
                #1 rst_n = 1'b0;
                #1 checkResetOutputs("abort");
                exp_q.delete();
                aborted = 1'b1;
            end
            if (!seen_done && !aborted) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;

        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("we_in_reset", 32'(vm_we), 0);
            end
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("we_after_reset", 32'(vm_we), 0);
                checkOutput("busy_after_reset", 32'(busy), 0);
            end
        end else begin
            if (!seen_done) checkOutput("done_timeout", c, done_exp);
            @(negedge clk);
            checkOutput("busy_after_done", 32'(busy), 0);
            checkOutput("done_one_cycle", 32'(done), 0);
            checkOutput("missing_writes", exp_q.size(), 0);
            @(negedge clk);
            checkOutput("still_idle", 32'(busy), 0);
            checkOutput("idle_we", 32'(vm_we), 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        remove  = 1'b0;
        src_sel = 2'd0;
        xloc    = 10'd0;
        yloc    = 9'd0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 256; a++) rom_mem[k][a] = 6'h3F;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 3x2 solid draw");
        for (int i = 0; i < 6; i++) spr_pix[i] = 6'h15;
        applyStimulus(1, 1'b0, 10, 2, 3, 2, 0, 0);

        $display("[TB] 3x2 with transparent pixel, draw and remove");
        spr_pix[1] = 6'h24;
        applyStimulus(1, 1'b0, 10, 2, 3, 2, 0, 0);
        applyStimulus(1, 1'b1, 10, 2, 3, 2, 0, 0);

        $display("[TB] empty sprite");
        applyStimulus(2, 1'b0, 10, 2, 0, 5, 0, 0);

        $display("[TB] right and bottom edges");
        for (int i = 0; i < 4; i++) spr_pix[i] = 6'(i + 1);
        applyStimulus(0, 1'b0, 638, 0, 4, 1, 0, 0);
        applyStimulus(3, 1'b0, 5, 479, 2, 2, 0, 0);

        $display("[TB] random 5x3 sprite from ROM 3");
        for (int i = 0; i < 15; i++) spr_pix[i] = 6'($urandom_range(0, 63));
        spr_pix[4] = 6'h24;
        spr_pix[9] = 6'h24;
        applyStimulus(3, 1'b0, 100, 50, 5, 3, 0, 0);

        $display("[TB] start re-pulsed while busy");
        applyStimulus(2, 1'b0, 200, 10, 5, 3, 3, 0);

        $display("[TB] reset mid-blit then normal blit");
        for (int i = 0; i < 6; i++) spr_pix[i] = 6'h15;
        applyStimulus(1, 1'b0, 10, 2, 3, 2, 0, 7);
        applyStimulus(1, 1'b0, 10, 2, 3, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
